select_encode_regfile: RTL and testbench
========================================

Name: select_encode_regfile

Overview:
- Receiving end of the datapath bus: decodes the IR register fields into per-register load and drive strobes, and captures BusMuxOut into the selected general register, HI or LO.
- Emits the one-hot R0out..R15out drive requests consumed by the bus encoder/mux.
- Supplies the register contents, HI, LO and the sign-extended constant C back to the bus mux inputs.
- Sits between the control unit (Gra/Grb/Grc/Rin/Rout/BAout strobes) and the bus.

Parameters:
- DATA_WIDTH, 32, width of the bus and every register.
- NUM_REGS, 16, number of general registers; the field width is log2(NUM_REGS) = 4.
- C_WIDTH, 19, width of the IR constant field before sign extension.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- clear  input  1  synchronous, active-low reset.
- BusMuxOut  input  32  current bus value; the write data source.
- IR  input  32  instruction register; Ra=IR[26:23], Rb=IR[22:19], Rc=IR[18:15], C=IR[18:0].
- Gra, Grb, Grc  input  1 each  select Ra, Rb or Rc as the target field.
- Rin  input  1  load the selected general register from BusMuxOut.
- Rout  input  1  request that the selected general register drive the bus.
- BAout  input  1  base-address read; forces the R0 bus view to zero.
- HIin, LOin  input  1 each  load HI or LO from BusMuxOut.
- Rout_onehot  output  16  bit i goes to the bus encoder's R(i)out input.
- BusMuxIn_R  output  512  packed register views; bits [32i+31:32i] hold Ri.
- BusMuxIn_HI, BusMuxIn_LO  output  32 each  HI and LO contents.
- C_sign_extended  output  32  IR[18:0] sign-extended from bit 18.
- sel_err  output  1  sticky flag: more than one Gr* was asserted while Rin or Rout was high.

Behaviour:
- Reset: when clear=0 at a rising edge, R0..R15, HI, LO = 0 and sel_err = 0. Reset takes priority over every simultaneous load.
- Field select is combinational, priority Gra > Grb > Grc. If no Gr* is asserted, no register is selected.
- Writes:
  - Rin=1 with a valid selection: Rsel <= BusMuxOut at the rising edge (1-cycle write latency).
  - Rin=1 with no Gr* asserted: no register changes and sel_err is not set.
  - R0 is physically writable; only its bus view is masked.
- HIin and LOin load independently and may coincide with Rin. All enabled targets load the same BusMuxOut value in the same edge.
- Reads:
  - Rout_onehot is combinational: when Rout=1 and a selection exists, exactly one bit is set; otherwise all bits are 0.
  - BusMuxIn_R slice 0 = BAout ? 0 : R0. The other slices always show register contents.
  - Rin and Rout on the same register in the same cycle: the bus carries the old value and the register holds the new value after the edge. There is no bypass.
- sel_err: set at the edge when (Rin|Rout) and two or more of Gra/Grb/Grc are high. It holds until clear=0. The write still proceeds using the priority winner.
- C_sign_extended: purely combinational from IR with no register stage. Bits [31:19] = IR[18].
- No output is X after reset. Unselected registers hold their values indefinitely.

Decomposition:
- Shared package mini_src_pkg:
  - DATA_WIDTH.
  - IR field position constants: RA_MSB/LSB, RB_MSB/LSB, RC_MSB/LSB, C_MSB.
  - NUM_REGS.
- One sub-module, reg32_en: a 32-bit register with synchronous active-low clear and load enable. Instantiated 18 times (R0..R15, HI, LO).
- Field select, the 4-to-16 decode and sign extension stay inline in select_encode_regfile.

Test Plan:
- Reset: hold clear=0 for 2 cycles with Rin=1 and BusMuxOut=0xFFFFFFFF -> all BusMuxIn_R slices, HI and LO = 0; sel_err = 0.
- Write/read: IR Ra=5, Gra=1, Rin=1, bus=0x12345678 for one edge; next cycle Rin=0, Rout=1 -> R5 = 0x12345678; Rout_onehot = 0x0020.
- BAout: write 0xDEADBEEF to R0, then BAout=1 -> slice 0 reads 0; with BAout=0 it reads 0xDEADBEEF.
- Same-cycle read/write: R3=0xA, bus=0xB, Grb selects R3, Rin=1, Rout=1 -> Rout_onehot = 0x0008 during the cycle; R3 = 0xB after the edge.
- Multi-select: Gra(Ra=1) and Grc(Rc=2) both high, Rin=1, bus=0x77 -> R1 = 0x77, R2 unchanged, sel_err = 1 and held until clear=0.
- Sign extension: IR[18:0] = 0x40000 -> C_sign_extended = 0xFFFC0000; IR[18:0] = 0x3FFFF -> 0x0003FFFF.

Source files
------------

// File: rtl/mini_src_pkg.sv
// Shared constants for the register-select / register-file slice: widths and IR field positions.
// Latency: none (constants only).
// Backpressure: none (constants only).
package mini_src_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int NUM_REGS   = 16;
    localparam int REG_IDX_W  = $clog2(NUM_REGS);
    localparam int C_WIDTH    = 19;

    // Register fields inside the instruction word
    localparam int RA_MSB = 26;
    localparam int RA_LSB = 23;
    localparam int RB_MSB = 22;
    localparam int RB_LSB = 19;
    localparam int RC_MSB = 18;
    localparam int RC_LSB = 15;

    // Immediate constant occupies IR[C_MSB:0]
    localparam int C_MSB  = C_WIDTH - 1;

endpackage

// File: rtl/select_encode_regfile_if.sv
// Bus-side bundle between the control unit / bus mux and the register file.
// Latency: wires only; timing is set by the modules on either side.
// Backpressure: none; strobes are level-sensitive and sampled every cycle.
interface select_encode_regfile_if;
    import mini_src_pkg::*;

    // Control unit and bus towards the register file
    logic [DATA_WIDTH-1:0]          BusMuxOut;
    logic [DATA_WIDTH-1:0]          IR;
    logic                           Gra;
    logic                           Grb;
    logic                           Grc;
    logic                           Rin;
    logic                           Rout;
    logic                           BAout;
    logic                           HIin;
    logic                           LOin;

    // Register file towards the bus encoder and mux
    logic [NUM_REGS-1:0]            Rout_onehot;
    logic [NUM_REGS*DATA_WIDTH-1:0] BusMuxIn_R;
    logic [DATA_WIDTH-1:0]          BusMuxIn_HI;
    logic [DATA_WIDTH-1:0]          BusMuxIn_LO;
    logic [DATA_WIDTH-1:0]          C_sign_extended;
    logic                           sel_err;

    modport master (
        output BusMuxOut, IR, Gra, Grb, Grc, Rin, Rout, BAout, HIin, LOin,
        input  Rout_onehot, BusMuxIn_R, BusMuxIn_HI, BusMuxIn_LO, C_sign_extended, sel_err
    );

    modport slave (
        input  BusMuxOut, IR, Gra, Grb, Grc, Rin, Rout, BAout, HIin, LOin,
        output Rout_onehot, BusMuxIn_R, BusMuxIn_HI, BusMuxIn_LO, C_sign_extended, sel_err
    );

endinterface

// File: rtl/select_encode_regfile_reg32_en.sv
// Single data-width register with load enable and synchronous active-low clear.
// Latency: 1 cycle from d_i/en_i to q_o.
// Backpressure: none; holds its value whenever en_i is low.
module reg32_en
    import mini_src_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  clear_i,
    input  logic                  en_i,
    input  logic [DATA_WIDTH-1:0] d_i,
    output logic [DATA_WIDTH-1:0] q_o
);

    logic [DATA_WIDTH-1:0] data_q;

    // Clear wins over load; otherwise capture d_i when enabled
    always_ff @(posedge clk_i) begin
        if (!clear_i) begin
            data_q <= '0;
        end else if (en_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/select_encode_regfile.sv
// Decodes IR register fields into load/drive strobes and holds R0..R15, HI, LO for the bus.
// Latency: writes land 1 cycle after the strobe; Rout_onehot, bus views and C are combinational.
// Backpressure: none; every strobe is acted on in the cycle it is presented.
module select_encode_regfile
    import mini_src_pkg::*;
(
    input  logic                   clock,
    input  logic                   clear,
    select_encode_regfile_if.slave bus
);

    logic [REG_IDX_W-1:0]           sel_idx;
    logic                           sel_vld;
    logic                           multi_sel;
    logic [NUM_REGS-1:0]            sel_onehot;
    logic [NUM_REGS-1:0]            load_en;
    logic [DATA_WIDTH-1:0]          reg_q [NUM_REGS];
    logic [DATA_WIDTH-1:0]          hi_q;
    logic [DATA_WIDTH-1:0]          lo_q;
    logic [NUM_REGS*DATA_WIDTH-1:0] r_view;
    logic                           sel_err_d;
    logic                           sel_err_q;
    logic                           unused_ir;

    // Field select with Gra > Grb > Grc priority; nothing selected when none is asserted
    always_comb begin
        sel_idx = '0;
        sel_vld = 1'b0;
        if (bus.Gra) begin
            sel_idx = bus.IR[RA_MSB:RA_LSB];
            sel_vld = 1'b1;
        end else if (bus.Grb) begin
            sel_idx = bus.IR[RB_MSB:RB_LSB];
            sel_vld = 1'b1;
        end else if (bus.Grc) begin
            sel_idx = bus.IR[RC_MSB:RC_LSB];
            sel_vld = 1'b1;
        end
    end

    assign multi_sel  = (bus.Gra & bus.Grb) | (bus.Gra & bus.Grc) | (bus.Grb & bus.Grc);
    assign sel_onehot = sel_vld ? (NUM_REGS'(1) << sel_idx) : '0;
    assign load_en    = bus.Rin  ? sel_onehot : '0;

    assign bus.Rout_onehot = bus.Rout ? sel_onehot : '0;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        reg32_en u_reg (
            .clk_i   (clock),
            .clear_i (clear),
            .en_i    (load_en[i]),
            .d_i     (bus.BusMuxOut),
            .q_o     (reg_q[i])
        );
    end

    reg32_en u_hi (
        .clk_i   (clock),
        .clear_i (clear),
        .en_i    (bus.HIin),
        .d_i     (bus.BusMuxOut),
        .q_o     (hi_q)
    );

    reg32_en u_lo (
        .clk_i   (clock),
        .clear_i (clear),
        .en_i    (bus.LOin),
        .d_i     (bus.BusMuxOut),
        .q_o     (lo_q)
    );

    // Pack register views for the bus mux; R0 reads as zero during a base-address read
    always_comb begin
        r_view = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            r_view[DATA_WIDTH*i +: DATA_WIDTH] = reg_q[i];
        end
        if (bus.BAout) begin
            r_view[DATA_WIDTH-1:0] = '0;
        end
    end

    assign bus.BusMuxIn_R  = r_view;
    assign bus.BusMuxIn_HI = hi_q;
    assign bus.BusMuxIn_LO = lo_q;

    assign bus.C_sign_extended = {{(DATA_WIDTH-C_WIDTH){bus.IR[C_MSB]}}, bus.IR[C_MSB:0]};

    // Ambiguous select is sticky until reset; the access itself still uses the priority winner
    always_comb begin
        sel_err_d = sel_err_q | ((bus.Rin | bus.Rout) & multi_sel);
    end

    // Error flag register
    always_ff @(posedge clock) begin
        if (!clear) begin
            sel_err_q <= 1'b0;
        end else begin
            sel_err_q <= sel_err_d;
        end
    end

    assign bus.sel_err = sel_err_q;

    // Opcode bits above the Ra field are not used by this block
    assign unused_ir = ^bus.IR[DATA_WIDTH-1:RA_MSB+1];

endmodule

// File: tb/tb_select_encode_regfile.sv
// Self-checking bench for select_encode_regfile: directed scenarios plus randomized traffic.
// Latency: reference model updates at each rising edge, compared 1 time unit after.
// Backpressure: n/a.
module tb_select_encode_regfile;

    logic clock = 1'b0;
    logic clear = 1'b0;

    select_encode_regfile_if sif ();

    select_encode_regfile dut (
        .clock (clock),
        .clear (clear),
        .bus   (sif)
    );

    always #5 clock = ~clock;

    // Reference state
    logic [31:0] m_r [16];
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic        m_err;

    int n_checks = 0;
    int n_pass   = 0;

    // Index chosen by the Gr* strobes, or -1 when none
    function automatic int pick(input logic a, input logic b, input logic c, input logic [31:0] ir);
        if (a) return int'(ir[26:23]);
        if (b) return int'(ir[22:19]);
        if (c) return int'(ir[18:15]);
        return -1;
    endfunction

    function automatic logic [511:0] exp_view(input logic ba);
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[32*i +: 32] = m_r[i];
        if (ba) v[31:0] = 32'h0;
        return v;
    endfunction

    function automatic logic [15:0] exp_onehot();
        int k;
        k = pick(sif.Gra, sif.Grb, sif.Grc, sif.IR);
        if (sif.Rout && k >= 0) return 16'(1 << k);
        return 16'h0;
    endfunction

    function automatic logic [31:0] exp_c(input logic [31:0] ir);
        int v;
        v = int'(ir & 32'h7FFFF);
        if (v >= 262144) v = v - 524288;
        return 32'(v);
    endfunction

    // Apply one rising edge to the model from the currently driven inputs
    task automatic model_edge();
        int k;
        int ng;
        if (!clear) begin
            for (int i = 0; i < 16; i++) m_r[i] = 32'h0;
            m_hi  = 32'h0;
            m_lo  = 32'h0;
            m_err = 1'b0;
        end else begin
            k  = pick(sif.Gra, sif.Grb, sif.Grc, sif.IR);
            ng = int'(sif.Gra) + int'(sif.Grb) + int'(sif.Grc);
            if (sif.Rin && k >= 0) m_r[k] = sif.BusMuxOut;
            if (sif.HIin) m_hi = sif.BusMuxOut;
            if (sif.LOin) m_lo = sif.BusMuxOut;
            if ((sif.Rin || sif.Rout) && ng >= 2) m_err = 1'b1;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        sif.Gra = 0; sif.Grb = 0; sif.Grc = 0;
        sif.Rin = 0; sif.Rout = 0; sif.BAout = 0;
        sif.HIin = 0; sif.LOin = 0;
    endtask

    task automatic test_reset();
        clear = 1'b0;
        sif.BusMuxOut = 32'hFFFF_FFFF;
        sif.IR = 32'h0080_0000;
        sif.Gra = 1; sif.Grb = 1; sif.Rin = 1; sif.HIin = 1; sif.LOin = 1;
        tick();
        tick();
        idle();
        #1;
        n_checks++;
        if (sif.BusMuxIn_R !== 512'h0) $display("FAIL reset_regs got %h exp 0", sif.BusMuxIn_R);
        else n_pass++;
        n_checks++;
        if (sif.BusMuxIn_HI !== 32'h0 || sif.BusMuxIn_LO !== 32'h0)
            $display("FAIL reset_hilo got %h/%h exp 0/0", sif.BusMuxIn_HI, sif.BusMuxIn_LO);
        else n_pass++;
        n_checks++;
        if (sif.sel_err !== 1'b0) $display("FAIL reset_sel_err got %b exp 0", sif.sel_err);
        else n_pass++;
        clear = 1'b1;
    endtask

    task automatic test_write_read();
        idle();
        sif.IR = 32'(5) << 23;
        sif.Gra = 1; sif.Rin = 1; sif.BusMuxOut = 32'h1234_5678;
        tick();
        sif.Rin = 0; sif.Rout = 1;
        #1;
        n_checks++;
        if (sif.BusMuxIn_R[5*32 +: 32] !== 32'h1234_5678)
            $display("FAIL wr_r5 got %h exp 12345678", sif.BusMuxIn_R[5*32 +: 32]);
        else n_pass++;
        n_checks++;
        if (sif.Rout_onehot !== 16'h0020) $display("FAIL wr_onehot got %h exp 0020", sif.Rout_onehot);
        else n_pass++;
        n_checks++;
        if (sif.BusMuxIn_R !== exp_view(1'b0)) $display("FAIL wr_others got %h exp %h", sif.BusMuxIn_R, exp_view(1'b0));
        else n_pass++;
        // Rin with no selection must change nothing
        idle();
        sif.Rin = 1; sif.BusMuxOut = 32'hCAFE_F00D;
        #1;
        n_checks++;
        if (sif.Rout_onehot !== 16'h0) $display("FAIL nosel_onehot got %h exp 0", sif.Rout_onehot);
        else n_pass++;
        tick();
        idle();
        n_checks++;
        if (sif.BusMuxIn_R !== exp_view(1'b0) || sif.sel_err !== 1'b0)
            $display("FAIL nosel_write got %h err %b exp %h err 0", sif.BusMuxIn_R, sif.sel_err, exp_view(1'b0));
        else n_pass++;
    endtask

    task automatic test_baout();
        idle();
        sif.IR = 32'h0;
        sif.Gra = 1; sif.Rin = 1; sif.BusMuxOut = 32'hDEAD_BEEF;
        tick();
        idle();
        sif.BAout = 1;
        #1;
        n_checks++;
        if (sif.BusMuxIn_R[31:0] !== 32'h0) $display("FAIL baout_r0 got %h exp 0", sif.BusMuxIn_R[31:0]);
        else n_pass++;
        sif.BAout = 0;
        #1;
        n_checks++;
        if (sif.BusMuxIn_R[31:0] !== 32'hDEAD_BEEF) $display("FAIL r0_view got %h exp deadbeef", sif.BusMuxIn_R[31:0]);
        else n_pass++;
    endtask

    task automatic test_same_cycle();
        idle();
        sif.IR = 32'(3) << 19;
        sif.Grb = 1; sif.Rin = 1; sif.BusMuxOut = 32'hA;
        tick();
        sif.BusMuxOut = 32'hB; sif.Rout = 1;
        #1;
        n_checks++;
        if (sif.Rout_onehot !== 16'h0008) $display("FAIL rw_onehot got %h exp 0008", sif.Rout_onehot);
        else n_pass++;
        n_checks++;
        if (sif.BusMuxIn_R[3*32 +: 32] !== 32'hA) $display("FAIL rw_old got %h exp a", sif.BusMuxIn_R[3*32 +: 32]);
        else n_pass++;
        tick();
        idle();
        n_checks++;
        if (sif.BusMuxIn_R[3*32 +: 32] !== 32'hB) $display("FAIL rw_new got %h exp b", sif.BusMuxIn_R[3*32 +: 32]);
        else n_pass++;
    endtask

    task automatic test_multi_select();
        logic [31:0] r2_old;
        idle();
        r2_old = m_r[2];
        sif.IR = (32'(1) << 23) | (32'(2) << 15);
        sif.Gra = 1; sif.Grc = 1; sif.Rin = 1; sif.BusMuxOut = 32'h77;
        tick();
        idle();
        n_checks++;
        if (sif.BusMuxIn_R[1*32 +: 32] !== 32'h77) $display("FAIL multi_r1 got %h exp 77", sif.BusMuxIn_R[1*32 +: 32]);
        else n_pass++;
        n_checks++;
        if (sif.BusMuxIn_R[2*32 +: 32] !== r2_old) $display("FAIL multi_r2 got %h exp %h", sif.BusMuxIn_R[2*32 +: 32], r2_old);
        else n_pass++;
        n_checks++;
        if (sif.sel_err !== 1'b1) $display("FAIL multi_err got %b exp 1", sif.sel_err);
        else n_pass++;
        for (int i = 0; i < 3; i++) tick();
        n_checks++;
        if (sif.sel_err !== 1'b1) $display("FAIL err_sticky got %b exp 1", sif.sel_err);
        else n_pass++;
        clear = 1'b0;
        tick();
        clear = 1'b1;
        n_checks++;
        if (sif.sel_err !== 1'b0) $display("FAIL err_clear got %b exp 0", sif.sel_err);
        else n_pass++;
    endtask

    task automatic test_sign_ext();
        sif.IR = 32'h0004_0000;
        #1;
        n_checks++;
        if (sif.C_sign_extended !== 32'hFFFC_0000) $display("FAIL sext_neg got %h exp fffc0000", sif.C_sign_extended);
        else n_pass++;
        sif.IR = 32'hFFF3_FFFF & 32'h0003_FFFF;
        #1;
        n_checks++;
        if (sif.C_sign_extended !== 32'h0003_FFFF) $display("FAIL sext_pos got %h exp 0003ffff", sif.C_sign_extended);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [15:0] eo;
        for (int it = 0; it < 300; it++) begin
            clear         = ($urandom_range(0, 39) != 0);
            sif.IR        = $urandom;
            sif.BusMuxOut = $urandom;
            sif.Gra       = ($urandom_range(0, 2) == 0);
            sif.Grb       = ($urandom_range(0, 2) == 0);
            sif.Grc       = ($urandom_range(0, 2) == 0);
            sif.Rin       = 1'($urandom);
            sif.Rout      = 1'($urandom);
            sif.BAout     = ($urandom_range(0, 3) == 0);
            sif.HIin      = ($urandom_range(0, 3) == 0);
            sif.LOin      = ($urandom_range(0, 3) == 0);
            #1;
            eo = exp_onehot();
            n_checks++;
            if (sif.Rout_onehot !== eo) $display("FAIL rnd_onehot it=%0d got %h exp %h", it, sif.Rout_onehot, eo);
            else n_pass++;
            n_checks++;
            if (sif.BusMuxIn_R !== exp_view(sif.BAout))
                $display("FAIL rnd_regs it=%0d got %h exp %h", it, sif.BusMuxIn_R, exp_view(sif.BAout));
            else n_pass++;
            n_checks++;
            if (sif.BusMuxIn_HI !== m_hi || sif.BusMuxIn_LO !== m_lo)
                $display("FAIL rnd_hilo it=%0d got %h/%h exp %h/%h", it, sif.BusMuxIn_HI, sif.BusMuxIn_LO, m_hi, m_lo);
            else n_pass++;
            n_checks++;
            if (sif.C_sign_extended !== exp_c(sif.IR))
                $display("FAIL rnd_sext it=%0d got %h exp %h", it, sif.C_sign_extended, exp_c(sif.IR));
            else n_pass++;
            n_checks++;
            if (sif.sel_err !== m_err) $display("FAIL rnd_err it=%0d got %b exp %b", it, sif.sel_err, m_err);
            else n_pass++;
            tick();
        end
        clear = 1'b1;
        idle();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) m_r[i] = 32'h0;
        m_hi = 32'h0; m_lo = 32'h0; m_err = 1'b0;
        sif.BusMuxOut = 32'h0;
        sif.IR        = 32'h0;
        idle();
        test_reset();
        test_write_read();
        test_baout();
        test_same_cycle();
        test_multi_select();
        test_sign_ext();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
